spartan_master_port: RTL and testbench
======================================

Name: spartan_master_port

Overview:
- Single-outstanding Spartan bus master; converts a simple local load/store request port into Spartan master-bus requests (SpM*) and collects slave responses (SpS*).
- Sits directly upstream of the Spartan-to-DPRAM slave bridge: drives its SpMBUS/SpMVLD, consumes its SpSBUS/SpSVLD.
- Reads: 1–16-beat incrementing bursts. Writes: single beat with byte mask.

Parameters:
- BWIDTH, 64, bus data width; 64, 128 or 256.
- ID_W, 8, transaction ID width; must satisfy ID_W <= BWIDTH-(BWIDTH/8)-41.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- REQ  in  1  local request valid
- REQ_RDY  out  1  request accepted when REQ && REQ_RDY
- REQ_WR  in  1  1=write, 0=read
- REQ_ADDR  in  32  byte address
- REQ_LEN  in  4  read beats-1 (ignored for writes)
- REQ_ID  in  ID_W  transaction ID
- REQ_MASK  in  BWIDTH/8  write byte enables
- REQ_WDATA  in  BWIDTH  write data
- RD_VLD  out  1  read data beat valid (registered)
- RD_DATA  out  BWIDTH  read data beat
- RD_LAST  out  1  final beat of burst
- DONE  out  1  one-cycle pulse: transaction complete
- ERR  out  1  valid with DONE: ID mismatch or beat-count mismatch
- SpMBUS  out  BWIDTH+2  master bus
- SpMVLD  out  1  master valid
- SpMRDY  in  1  master ready
- SpSBUS  in  BWIDTH+2  slave response bus
- SpSVLD  in  1  slave valid
- SpSRDY  out  1  slave ready

Behaviour:
- Reset RST, asynchronous, active-high; clock CLK. On reset: state IDLE; SpMVLD, SpSRDY, RD_VLD, RD_LAST, DONE, ERR = 0; REQ_RDY = 1 (follows IDLE). Data/address/ID registers need no reset.
- Reset mid-transaction: return to IDLE immediately, no DONE; the partial bus transaction is abandoned.
- Master codes, SpMBUS[BWIDTH+1:BWIDTH]: 00 read header, 01 write header, 10 write data, 11 write data last.
- Header fields: [31:0] addr; [35:32] len; [38:36] 0; [40:39] inc mode (01 if len!=0, else 00); [41+:ID_W] id; remaining bits up to BWIDTH-BWIDTH/8-1 are 0; [BWIDTH-1 -: BWIDTH/8] mask (write only, 0 for read).
- Slave codes, SpSBUS[BWIDTH+1:BWIDTH]: 01 read response header (id at [41+:ID_W]), 10 read data, 11 read data last, 00 write response header (id at [41+:ID_W]).
- Transfers complete on VLD && RDY, per channel.
- FSM states: IDLE, RD_HDR, RD_WAIT, RD_DATA, WR_HDR, WR_DATA, WR_RESP.
- IDLE: REQ_RDY=1. On accept, latch all request fields, clear beat counter and error flag; next state WR_HDR or RD_HDR. Header is driven the cycle after accept.
- RD_HDR: SpMVLD=1 with read header; SpSRDY=1, because the slave only accepts the read header while SpSRDY is high.
  - On SpMRDY: if SpSVLD with code 01 in the same cycle, consume it and go to RD_DATA; otherwise go to RD_WAIT.
  - A code-01 response arriving before SpMRDY is also consumed; stay in RD_HDR until SpMRDY.
- RD_WAIT: SpSRDY=1; on SpSVLD with code 01, go to RD_DATA.
- Response header checks: ID compared with latched ID; mismatch sets the error flag. Any other code in RD_HDR or RD_WAIT sets the error flag and the beat is dropped.
- RD_DATA: SpSRDY=1; each code-1x beat drives RD_VLD/RD_DATA next cycle and increments a 5-bit beat counter.
  - Code 11: RD_LAST=1 with that beat; DONE pulses the same cycle as RD_LAST; go to IDLE.
  - ERR set if the final count != len+1, or if the counter would exceed len+1 before code 11. On overflow, terminate with DONE and ERR and go to IDLE; the following beats are ignored.
- WR_HDR: SpMVLD=1 with write header; on SpMRDY go to WR_DATA.
- WR_DATA: SpMVLD=1, code 11, data = latched WDATA; on SpMRDY go to WR_RESP.
- WR_RESP: SpSRDY=1; on SpSVLD with code 00, check ID, pulse DONE (ERR if mismatch) next cycle; go to IDLE.
- SpSRDY=0 in IDLE, WR_HDR, WR_DATA; unexpected responses there are not consumed.
- SpMBUS is held stable while SpMVLD && !SpMRDY; SpMVLD never deasserts without a transfer.
- Back-to-back: REQ_RDY reasserts the cycle DONE pulses, so a new request may be accepted in the DONE cycle.
- Minimum latency: single-beat read with zero-wait slave gives DONE 3 cycles after accept; write gives 4.

Decomposition:
- Shared package spartan_pkg:
  - code constants SP_M_RD_HDR, SP_M_WR_HDR, SP_M_WR_DAT, SP_M_WR_LAST, SP_S_RD_HDR, SP_S_RD_DAT, SP_S_RD_LAST, SP_S_WR_RSP;
  - field bit positions (ADDR, LEN, INC, ID_LSB=41);
  - FSM state enum;
  - header-pack function.
- No sub-module; a single module is the natural unit.

Test Plan:
- Write, ADDR=0x1000, MASK=0x0F, WDATA=0x1122334455667788, ID=0x5A, SpMRDY/SpSVLD always-ready slave model:
  - SpMBUS shows code 01 with mask 0x0F and id 0x5A, then code 11 with the data.
  - Slave answers code 00 with id 0x5A → DONE=1, ERR=0.
- Read burst, ADDR=0x2000, LEN=3, slave returns 01-header then 10,10,10,11:
  - Header carries inc=01, len=3.
  - Four RD_VLD beats with RD_LAST on the 4th; DONE with ERR=0.
- Read where the response header arrives in the same cycle as SpMRDY → FSM skips RD_WAIT; first data is accepted the next cycle.
- SpMRDY held low 5 cycles in RD_HDR and WR_DATA → SpMBUS/SpMVLD stable throughout; SpSRDY=1 in RD_HDR, 0 in WR_DATA.
- Write response with id 0x5B against expected 0x5A → DONE=1, ERR=1. Read with LEN=3 receiving code 11 on the 2nd beat → DONE, ERR=1.
- RST asserted mid RD_DATA after 2 beats → outputs clear asynchronously, REQ_RDY=1, no DONE; the next request completes normally.

Source files
------------

// File: rtl/spartan_pkg.sv
// spartan_pkg: Spartan bus codes, header field positions, master FSM states
// and the header packer shared by the Spartan master port.
package spartan_pkg;

    localparam logic [1:0] SP_M_RD_HDR  = 2'b00;
    localparam logic [1:0] SP_M_WR_HDR  = 2'b01;
    localparam logic [1:0] SP_M_WR_DAT  = 2'b10;
    localparam logic [1:0] SP_M_WR_LAST = 2'b11;

    localparam logic [1:0] SP_S_RD_HDR  = 2'b01;
    localparam logic [1:0] SP_S_RD_DAT  = 2'b10;
    localparam logic [1:0] SP_S_RD_LAST = 2'b11;
    localparam logic [1:0] SP_S_WR_RSP  = 2'b00;

    localparam int SP_ADDR_LSB = 0;
    localparam int SP_LEN_LSB  = 32;
    localparam int SP_INC_LSB  = 39;
    localparam int SP_ID_LSB   = 41;
    localparam int SP_HDR_MAX  = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HDR,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_HDR,
        ST_WR_DATA,
        ST_WR_RESP
    } sp_state_e;

    // Packs addr/len/inc/id at the widest bus size; caller truncates and adds the mask.
    function automatic logic [SP_HDR_MAX-1:0] sp_hdr_pack(
        input logic [31:0]           addr,
        input logic [3:0]            len,
        input logic [SP_HDR_MAX-1:0] id
    );
        logic [SP_HDR_MAX-1:0] h;
        h                      = id << SP_ID_LSB;
        h[SP_ADDR_LSB +: 32]   = addr;
        h[SP_LEN_LSB +: 4]     = len;
        h[SP_INC_LSB +: 2]     = (len != 4'd0) ? 2'b01 : 2'b00;
        return h;
    endfunction

endpackage

// File: rtl/spartan_master_port.sv
// spartan_master_port: single-outstanding Spartan bus master turning local
// load/store requests into SpM* requests and collecting SpS* responses.
module spartan_master_port
    import spartan_pkg::*;
#(
    parameter int BWIDTH = 64,
    parameter int ID_W   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    output logic                  REQ_RDY,
    input  logic                  REQ_WR,
    input  logic [31:0]           REQ_ADDR,
    input  logic [3:0]            REQ_LEN,
    input  logic [ID_W-1:0]       REQ_ID,
    input  logic [BWIDTH/8-1:0]   REQ_MASK,
    input  logic [BWIDTH-1:0]     REQ_WDATA,
    output logic                  RD_VLD,
    output logic [BWIDTH-1:0]     RD_DATA,
    output logic                  RD_LAST,
    output logic                  DONE,
    output logic                  ERR,
    output logic [BWIDTH+1:0]     SpMBUS,
    output logic                  SpMVLD,
    input  logic                  SpMRDY,
    input  logic [BWIDTH+1:0]     SpSBUS,
    input  logic                  SpSVLD,
    output logic                  SpSRDY
);

    localparam int MW = BWIDTH / 8;

    sp_state_e         st_q, st_d;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [3:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic [MW-1:0]     mask_q;
    logic [BWIDTH-1:0] wdata_q;
    logic [BWIDTH-1:0] rd_data_q;
    logic [4:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rsp_q, rsp_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;
    logic              done_err_q, done_err_d;

    logic              accept;
    logic              s_fire;
    logic [1:0]        s_code;
    logic              s_id_ok;
    logic              s_rd_hdr;
    logic [4:0]        len_p1;
    logic [BWIDTH-1:0] hdr;

    assign accept   = REQ && REQ_RDY;
    assign s_fire   = SpSVLD && SpSRDY;
    assign s_code   = SpSBUS[BWIDTH+1:BWIDTH];
    assign s_id_ok  = SpSBUS[SP_ID_LSB +: ID_W] == id_q;
    assign s_rd_hdr = s_fire && s_code == SP_S_RD_HDR;
    assign len_p1   = 5'(len_q) + 5'd1;

    // Latched fields only change in IDLE, so the header is stable under back-pressure.
    assign hdr = BWIDTH'(sp_hdr_pack(addr_q, len_q, SP_HDR_MAX'(id_q)))
               | {wr_q ? mask_q : MW'(0), {(BWIDTH-MW){1'b0}}};

    assign REQ_RDY = st_q == ST_IDLE;
    assign SpMVLD  = st_q inside {ST_RD_HDR, ST_WR_HDR, ST_WR_DATA};
    assign SpSRDY  = st_q inside {ST_RD_HDR, ST_RD_WAIT, ST_RD_DATA, ST_WR_RESP};
    assign SpMBUS  = st_q == ST_WR_DATA ? {SP_M_WR_LAST, wdata_q}
                   : {st_q == ST_WR_HDR ? SP_M_WR_HDR : SP_M_RD_HDR, hdr};
    assign RD_VLD  = rd_vld_q;
    assign RD_DATA = rd_data_q;
    assign RD_LAST = rd_last_q;
    assign DONE    = done_q;
    assign ERR     = done_err_q;

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rsp_d      = rsp_q;
        rd_vld_d   = 1'b0;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    st_d  = REQ_WR ? ST_WR_HDR : ST_RD_HDR;
                    cnt_d = 5'd0;
                    err_d = 1'b0;
                    rsp_d = 1'b0;
                end
            end
            ST_RD_HDR: begin
                if (s_fire) begin
                    rsp_d = rsp_q || s_rd_hdr;
                    err_d = err_q || !s_rd_hdr || !s_id_ok;
                end
                // An early response header is remembered so it is not awaited again.
                if (SpMRDY)
                    st_d = (rsp_q || s_rd_hdr) ? ST_RD_DATA : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (s_fire) begin
                    err_d = err_q || !s_rd_hdr || !s_id_ok;
                    if (s_rd_hdr)
                        st_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (s_fire && (s_code == SP_S_RD_DAT || s_code == SP_S_RD_LAST)) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_d > len_p1) begin
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                        st_d       = ST_IDLE;
                    end else begin
                        rd_vld_d = 1'b1;
                        if (s_code == SP_S_RD_LAST) begin
                            rd_last_d  = 1'b1;
                            done_d     = 1'b1;
                            done_err_d = err_q || cnt_d != len_p1;
                            st_d       = ST_IDLE;
                        end
                    end
                end
            end
            ST_WR_HDR: begin
                if (SpMRDY)
                    st_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (SpMRDY)
                    st_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (s_fire && s_code == SP_S_WR_RSP) begin
                    done_d     = 1'b1;
                    done_err_d = err_q || !s_id_ok;
                    st_d       = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q       <= ST_IDLE;
            cnt_q      <= 5'd0;
            err_q      <= 1'b0;
            rsp_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rsp_q      <= rsp_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            wr_q    <= REQ_WR;
            addr_q  <= REQ_ADDR;
            len_q   <= REQ_WR ? 4'd0 : REQ_LEN;
            id_q    <= REQ_ID;
            mask_q  <= REQ_MASK;
            wdata_q <= REQ_WDATA;
        end
        if (rd_vld_d)
            rd_data_q <= SpSBUS[BWIDTH-1:0];
    end

endmodule

// File: tb/tb_spartan_master_port.sv
// tb_spartan_master_port: directed vectors with hand-computed bus words for
// the Spartan master port (BWIDTH=64, ID_W=8).
module tb_spartan_master_port;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ, REQ_RDY, REQ_WR;
    logic [31:0] REQ_ADDR;
    logic [3:0]  REQ_LEN;
    logic [7:0]  REQ_ID, REQ_MASK;
    logic [63:0] REQ_WDATA, RD_DATA;
    logic        RD_VLD, RD_LAST, DONE, ERR;
    logic [65:0] SpMBUS, SpSBUS;
    logic        SpMVLD, SpMRDY, SpSVLD, SpSRDY;

    int n_tests = 0;
    int n_fail  = 0;

    spartan_master_port #(.BWIDTH(64), .ID_W(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RDY(REQ_RDY), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_ID(REQ_ID), .REQ_MASK(REQ_MASK),
        .REQ_WDATA(REQ_WDATA), .RD_VLD(RD_VLD), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .DONE(DONE), .ERR(ERR), .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
        .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] idf(input logic [7:0] id);
        return 64'(id) << 41;
    endfunction

    task automatic sresp(input logic [1:0] c, input logic [63:0] d);
        SpSVLD = 1'b1;
        SpSBUS = {c, d};
    endtask

    // Presents a request, checks it is accepted, returns in the header cycle.
    task automatic req(input logic wr, input logic [31:0] a, input logic [3:0] l,
                       input logic [7:0] id, input logic [7:0] m, input logic [63:0] wd);
        REQ = 1'b1; REQ_WR = wr; REQ_ADDR = a; REQ_LEN = l;
        REQ_ID = id; REQ_MASK = m; REQ_WDATA = wd;
        #1 chk("req_rdy", REQ_RDY, 1);
        tick;
        REQ = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; REQ = 0; REQ_WR = 0; REQ_ADDR = 0; REQ_LEN = 0; REQ_ID = 0;
        REQ_MASK = 0; REQ_WDATA = 0; SpMRDY = 0; SpSVLD = 0; SpSBUS = '0;
        repeat (2) tick;
        chk("rst_req_rdy", REQ_RDY, 1);
        chk("rst_mvld", SpMVLD, 0);
        chk("rst_srdy", SpSRDY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_rd_vld", RD_VLD, 0);
        RST = 1'b0;
        tick;

        // single-beat write, always-ready slave
        SpMRDY = 1'b1;
        req(1'b1, 32'h1000, 4'd0, 8'h5A, 8'h0F, 64'h1122334455667788);
        #1 chk("wr_hdr_bus", SpMBUS, 66'h1_0F00_B400_0000_1000);
        chk("wr_hdr_mvld", SpMVLD, 1);
        chk("wr_hdr_srdy", SpSRDY, 0);
        tick;
        #1 chk("wr_dat_bus", SpMBUS, 66'h3_1122_3344_5566_7788);
        chk("wr_dat_srdy", SpSRDY, 0);
        tick;
        sresp(2'b00, idf(8'h5A));
        #1 chk("wr_rsp_srdy", SpSRDY, 1);
        chk("wr_rsp_mvld", SpMVLD, 0);
        tick;
        SpSVLD = 1'b0;
        chk("wr_done", DONE, 1);
        chk("wr_err", ERR, 0);
        chk("wr_done_rdy", REQ_RDY, 1);
        tick;
        chk("wr_done_pulse", DONE, 0);

        // 4-beat read burst via RD_WAIT; mask input must not leak into header
        req(1'b0, 32'h2000, 4'd3, 8'h33, 8'hFF, 64'h0);
        #1 chk("rd_hdr_bus", SpMBUS, 66'h0_0000_6683_0000_2000);
        chk("rd_hdr_srdy", SpSRDY, 1);
        tick;
        chk("rd_wait_mvld", SpMVLD, 0);
        sresp(2'b01, idf(8'h33));
        tick;
        for (int i = 0; i < 4; i++) begin
            sresp(i == 3 ? 2'b11 : 2'b10, 64'hA0 + 64'(i));
            tick;
            chk("rd_beat_vld", RD_VLD, 1);
            chk("rd_beat_data", RD_DATA, 64'hA0 + 64'(i));
            chk("rd_beat_last", RD_LAST, i == 3);
            chk("rd_beat_done", DONE, i == 3);
        end
        SpSVLD = 1'b0;
        chk("rd_err", ERR, 0);
        tick;

        // response header together with SpMRDY skips RD_WAIT: DONE 3 cycles after accept
        req(1'b0, 32'h3000, 4'd0, 8'h44, 8'h00, 64'h0);
        sresp(2'b01, idf(8'h44));
        tick;
        sresp(2'b11, 64'hBEEF);
        tick;
        SpSVLD = 1'b0;
        chk("fast_vld", RD_VLD, 1);
        chk("fast_data", RD_DATA, 64'hBEEF);
        chk("fast_last", RD_LAST, 1);
        chk("fast_done", DONE, 1);
        chk("fast_err", ERR, 0);
        tick;

        // master back-pressure in RD_HDR
        SpMRDY = 1'b0;
        req(1'b0, 32'h4000, 4'd0, 8'h11, 8'h00, 64'h0);
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_rd_bus", SpMBUS, 66'h0_0000_2200_0000_4000);
            chk("stall_rd_mvld", SpMVLD, 1);
            chk("stall_rd_srdy", SpSRDY, 1);
            tick;
        end
        SpMRDY = 1'b1;
        sresp(2'b01, idf(8'h11));
        tick;
        sresp(2'b11, 64'h1);
        tick;
        SpSVLD = 1'b0;
        chk("stall_rd_done", DONE, 1);
        chk("stall_rd_err", ERR, 0);
        tick;

        // master back-pressure in WR_DATA, then response with the wrong ID
        req(1'b1, 32'h5000, 4'd0, 8'h5A, 8'hF0, 64'hCAFE_F00D_1234_5678);
        tick;
        SpMRDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_wr_bus", SpMBUS, 66'h3_CAFE_F00D_1234_5678);
            chk("stall_wr_mvld", SpMVLD, 1);
            chk("stall_wr_srdy", SpSRDY, 0);
            tick;
        end
        SpMRDY = 1'b1;
        tick;
        sresp(2'b00, idf(8'h5B));
        tick;
        SpSVLD = 1'b0;
        chk("wr_badid_done", DONE, 1);
        chk("wr_badid_err", ERR, 1);
        tick;

        // LEN=3 read terminated by code 11 on the 2nd beat
        req(1'b0, 32'h6000, 4'd3, 8'h66, 8'h00, 64'h0);
        sresp(2'b01, idf(8'h66));
        tick;
        sresp(2'b10, 64'h1);
        tick;
        chk("short_b1_vld", RD_VLD, 1);
        chk("short_b1_done", DONE, 0);
        sresp(2'b11, 64'h2);
        tick;
        SpSVLD = 1'b0;
        chk("short_last", RD_LAST, 1);
        chk("short_done", DONE, 1);
        chk("short_err", ERR, 1);
        tick;

        // LEN=0 read with a surplus beat before code 11
        req(1'b0, 32'h6100, 4'd0, 8'h77, 8'h00, 64'h0);
        sresp(2'b01, idf(8'h77));
        tick;
        sresp(2'b10, 64'h1);
        tick;
        chk("ovf_b1_vld", RD_VLD, 1);
        chk("ovf_b1_done", DONE, 0);
        sresp(2'b10, 64'h2);
        tick;
        SpSVLD = 1'b0;
        chk("ovf_vld", RD_VLD, 0);
        chk("ovf_done", DONE, 1);
        chk("ovf_err", ERR, 1);
        chk("ovf_rdy", REQ_RDY, 1);
        tick;

        // asynchronous reset after two beats of a 4-beat read
        req(1'b0, 32'h7000, 4'd3, 8'h12, 8'h00, 64'h0);
        sresp(2'b01, idf(8'h12));
        tick;
        sresp(2'b10, 64'h1);
        tick;
        sresp(2'b10, 64'h2);
        tick;
        SpSVLD = 1'b0;
        chk("pre_rst_vld", RD_VLD, 1);
        #2 RST = 1'b1;
        #1 chk("arst_vld", RD_VLD, 0);
        chk("arst_done", DONE, 0);
        chk("arst_rdy", REQ_RDY, 1);
        chk("arst_srdy", SpSRDY, 0);
        tick;
        RST = 1'b0;
        tick;
        req(1'b1, 32'h7000, 4'd0, 8'h12, 8'hFF, 64'h55);
        tick;
        tick;
        sresp(2'b00, idf(8'h12));
        tick;
        SpSVLD = 1'b0;
        chk("post_rst_done", DONE, 1);
        chk("post_rst_err", ERR, 0);

        // back-to-back: new request accepted in the DONE cycle
        req(1'b0, 32'h8000, 4'd0, 8'h21, 8'h00, 64'h0);
        sresp(2'b01, idf(8'h21));
        tick;
        sresp(2'b11, 64'h99);
        tick;
        SpSVLD = 1'b0;
        chk("b2b_done", DONE, 1);
        chk("b2b_data", RD_DATA, 64'h99);
        chk("b2b_err", ERR, 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
